// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the HyperRAM multi-channel front end:
//   - state_e     : transaction FSM encoding (IDLE, CMD, DATA, FIN)
//   - CA_*        : bit positions inside the 48-bit command/address word
//   - clog2()     : ceiling log2, used for parameter-derived widths
package ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam int CA_W       = 48;
    localparam int CA_RW      = 47;  // 1 = read
    localparam int CA_AS      = 46;  // address space, 0 = memory
    localparam int CA_BT      = 45;  // burst type, 1 = linear
    localparam int CA_ADDR_HI = 44;  // upper address field holds addr[31:3]
    localparam int CA_ADDR_LO = 16;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_rr_arb.sv
// ram_rr_arb
// Purely combinational NCH-wide arbiter.
//   req  : request vector
//   ptr  : round-robin search start (ignored in fixed-priority mode)
//   gnt  : one-hot grant
//   idx  : binary index of the granted channel
//   vld  : at least one request present
// PRIO_MODE = 0 searches req starting at ptr and wrapping; PRIO_MODE = 1
// searches from channel 0 upward, so the lowest index wins.
module ram_rr_arb
    import ram_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int PRIO_MODE = 0,
    parameter int IW        = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           vld
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        vld      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            cand     = (PRIO_MODE != 0) ? k : ((int'(ptr) + k) % NCH);
            cand_idx = IW'(cand);
            // First hit in search order wins; later hits are masked by vld.
            if (!vld && req[cand_idx]) begin
                vld = 1'b1;
                idx = cand_idx;
            end
        end
        if (vld) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arb_mc.sv
// ram_arb_mc
// Multi-channel front end for the HyperRAM PHY. NCH identical host channels
// compete for the PHY; the winner's command/address word is sent as three
// 16-bit beats, then its write data is forwarded to (or read data returned
// from) the PHY for one word or a BURST_LEN-word burst.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ch_req/rwn/burst/addr    per-channel request and its attributes
//   ch_ack                   one-cycle grant pulse to the winning channel
//   ch_txm/ch_txd            per-channel write mask/data (packed)
//   ch_txd_ack               write word consumed (granted channel only)
//   ch_rxd, ch_rxd_vld       read data (broadcast) and per-channel valid
//   phy_req, phy_fin         transaction active / end pulse
//   phy_rwn                  direction of the current transaction
//   phy_txc, phy_txc_ack     command beat and its handshake
//   phy_txm, phy_txd, phy_txd_ack   write mask/data and handshake
//   phy_rxd, phy_rxd_vld     read data from the PHY
module ram_arb_mc
    import ram_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int AW        = 32,
    parameter int DW        = 16,
    parameter int BURST_LEN = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_rwn,
    input  logic [NCH-1:0]    ch_burst,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH-1:0]    ch_ack,
    input  logic [NCH*2-1:0]  ch_txm,
    input  logic [NCH*DW-1:0] ch_txd,
    output logic [NCH-1:0]    ch_txd_ack,
    output logic [DW-1:0]     ch_rxd,
    output logic [NCH-1:0]    ch_rxd_vld,
    output logic              phy_req,
    output logic              phy_fin,
    output logic              phy_rwn,
    output logic [15:0]       phy_txc,
    input  logic              phy_txc_ack,
    output logic [1:0]        phy_txm,
    output logic [DW-1:0]     phy_txd,
    input  logic              phy_txd_ack,
    input  logic [DW-1:0]     phy_rxd,
    input  logic              phy_rxd_vld
);

    localparam int IW = clog2(NCH);
    localparam int CW = clog2(BURST_LEN) + 1;

    // ------------------------------------------------------------------
    // Per-channel views of the packed buses
    // ------------------------------------------------------------------
    logic [AW-1:0] addr_a [NCH];
    logic [DW-1:0] txd_a  [NCH];
    logic [1:0]    txm_a  [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign addr_a[i] = ch_addr[i*AW +: AW];
        assign txd_a[i]  = ch_txd[i*DW +: DW];
        assign txm_a[i]  = ch_txm[i*2 +: 2];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [IW-1:0]  gidx_q,  gidx_d;
    logic           rwn_q,   rwn_d;
    logic           burst_q, burst_d;
    logic [AW-1:0]  addr_q,  addr_d;
    logic [1:0]     beat_q,  beat_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [IW-1:0]  ptr_q,   ptr_d;
    logic [NCH-1:0] ack_q,   ack_d;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           arb_vld;

    ram_rr_arb #(
        .NCH       (NCH),
        .PRIO_MODE (PRIO_MODE),
        .IW        (IW)
    ) u_arb (
        .req (ch_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    // ------------------------------------------------------------------
    // Command/address word
    // ------------------------------------------------------------------
    logic [31:0]     addr32;
    logic [CA_W-1:0] ca;

    assign addr32 = 32'(addr_q);

    // Bits [15:3] stay 0: the device takes only the halfword offset within
    // a 16-byte row in the low field, the rest of the address sits above.
    always_comb begin
        ca                        = '0;
        ca[CA_RW]                 = rwn_q;
        ca[CA_AS]                 = 1'b0;
        ca[CA_BT]                 = 1'b1;
        ca[CA_ADDR_HI:CA_ADDR_LO] = addr32[31:3];
        ca[2:0]                   = addr32[2:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic word_evt;

    // Only the handshake that matches the transaction direction counts.
    assign word_evt = rwn_q ? phy_rxd_vld : phy_txd_ack;

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        rwn_d   = rwn_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gidx_d  = arb_idx;
                    rwn_d   = ch_rwn[arb_idx];
                    burst_d = ch_burst[arb_idx];
                    addr_d  = addr_a[arb_idx];
                    beat_d  = 2'd0;
                    ack_d   = arb_gnt;
                    ptr_d   = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                if (phy_txc_ack) begin
                    if (beat_q == 2'd2) begin
                        cnt_d   = burst_q ? CW'(BURST_LEN) : CW'(1);
                        state_d = ST_DATA;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end

            ST_DATA: begin
                if (word_evt) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            rwn_q   <= 1'b0;
            burst_q <= 1'b0;
            addr_q  <= '0;
            beat_q  <= 2'd0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            rwn_q   <= rwn_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_wr;
    logic in_rd;

    assign in_wr = (state_q == ST_DATA) && !rwn_q;
    assign in_rd = (state_q == ST_DATA) &&  rwn_q;

    assign ch_ack  = ack_q;
    assign phy_req = (state_q == ST_CMD) || (state_q == ST_DATA);
    assign phy_fin = (state_q == ST_FIN);
    assign phy_rwn = rwn_q;

    // Read data is broadcast; it is only forced low while reset is held so
    // that every output is quiet during reset.
    assign ch_rxd = rst ? phy_rxd : '0;

    always_comb begin
        phy_txc = 16'h0000;
        if (state_q == ST_CMD) begin
            unique case (beat_q)
                2'd0:    phy_txc = ca[47:32];
                2'd1:    phy_txc = ca[31:16];
                default: phy_txc = ca[15:0];
            endcase
        end
    end

    always_comb begin
        phy_txd    = '0;
        phy_txm    = 2'b00;
        ch_txd_ack = '0;
        ch_rxd_vld = '0;
        if (in_wr) begin
            phy_txd            = txd_a[gidx_q];
            phy_txm            = txm_a[gidx_q];
            ch_txd_ack[gidx_q] = phy_txd_ack;
        end
        if (in_rd) begin
            ch_rxd_vld[gidx_q] = phy_rxd_vld;
        end
    end

endmodule

// File: tb/tb_ram_arb_mc.sv
module tb_ram_arb_mc;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int BL  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_req, ch_rwn, ch_burst;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*2-1:0]  ch_txm;
    logic [NCH*DW-1:0] ch_txd;
    logic              phy_txc_ack, phy_txd_ack, phy_rxd_vld;
    logic [DW-1:0]     phy_rxd;

    logic [NCH-1:0]    ch_ack, ch_txd_ack, ch_rxd_vld;
    logic [DW-1:0]     ch_rxd;
    logic              phy_req, phy_fin, phy_rwn;
    logic [15:0]       phy_txc;
    logic [1:0]        phy_txm;
    logic [DW-1:0]     phy_txd;

    // Second instance in fixed-priority mode with a PHY that always acks.
    logic [NCH-1:0]    req2;
    logic [NCH-1:0]    ack2, txd_ack2, rxd_vld2;
    logic [DW-1:0]     rxd2, txd2;
    logic              preq2, pfin2, prwn2;
    logic [15:0]       txc2;
    logic [1:0]        txm2;

    always #5 clk = ~clk;

    ram_arb_mc #(.NCH(NCH), .AW(AW), .DW(DW), .BURST_LEN(BL), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_rwn(ch_rwn), .ch_burst(ch_burst), .ch_addr(ch_addr),
        .ch_ack(ch_ack), .ch_txm(ch_txm), .ch_txd(ch_txd), .ch_txd_ack(ch_txd_ack),
        .ch_rxd(ch_rxd), .ch_rxd_vld(ch_rxd_vld),
        .phy_req(phy_req), .phy_fin(phy_fin), .phy_rwn(phy_rwn),
        .phy_txc(phy_txc), .phy_txc_ack(phy_txc_ack),
        .phy_txm(phy_txm), .phy_txd(phy_txd), .phy_txd_ack(phy_txd_ack),
        .phy_rxd(phy_rxd), .phy_rxd_vld(phy_rxd_vld)
    );

    ram_arb_mc #(.NCH(NCH), .AW(AW), .DW(DW), .BURST_LEN(BL), .PRIO_MODE(1)) dut_prio (
        .clk(clk), .rst(rst),
        .ch_req(req2), .ch_rwn(4'hF), .ch_burst(4'h0), .ch_addr('0),
        .ch_ack(ack2), .ch_txm(8'h00), .ch_txd('0), .ch_txd_ack(txd_ack2),
        .ch_rxd(rxd2), .ch_rxd_vld(rxd_vld2),
        .phy_req(preq2), .phy_fin(pfin2), .phy_rwn(prwn2),
        .phy_txc(txc2), .phy_txc_ack(1'b1),
        .phy_txm(txm2), .phy_txd(txd2), .phy_txd_ack(1'b1),
        .phy_rxd(16'h0000), .phy_rxd_vld(1'b1)
    );

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;   // reference round-robin pointer

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [NCH-1:0] req, input int ptr);
        for (int k = 0; k < NCH; k++) begin
            if (req[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    // Reference CA word built arithmetically from its field definitions.
    function automatic logic [15:0] ca_beat(input logic rwn, input logic [31:0] a, input int b);
        logic [47:0] ca;
        ca = (48'(rwn) << 47) | (48'h1 << 45) | (48'(a >> 3) << 16) | 48'(a & 32'h7);
        return ca[47 - 16*b -: 16];
    endfunction

    // One complete transaction, driven from a negedge with the DUT in IDLE.
    task automatic run_txn(input logic [NCH-1:0] req_v, input logic keep, input logic use_exp,
                           input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                           input logic spur, output logic [NCH-1:0] got_ack);
        int g, n, wc;
        logic r;
        logic [31:0] a;
        logic [15:0] eb [3];
        logic [15:0] wd, rd;
        logic [1:0] wm;

        ch_req = req_v;
        g = pick(req_v, ptr_m);
        r = ch_rwn[g];
        a = ch_addr[g*AW +: AW];
        n = ch_burst[g] ? BL : 1;
        if (use_exp) begin
            eb[0] = e0; eb[1] = e1; eb[2] = e2;
        end else begin
            for (int b = 0; b < 3; b++) eb[b] = ca_beat(r, a, b);
        end

        @(negedge clk);
        got_ack = ch_ack;
        check("grant", ch_ack, 4'b0001 << g);
        check("req_in_cmd", phy_req, 1'b1);
        check("rwn", phy_rwn, r);
        if (!keep) ch_req = '0;
        ptr_m = (g + 1) % NCH;

        for (int b = 0; b < 3; b++) begin
            wc = spur ? int'($urandom_range(1, 2)) : 0;
            repeat (wc) begin
                phy_rxd_vld = 1'b1;
                phy_txd_ack = 1'b1;
                #1;
                check("cmd_hold", phy_txc, eb[b]);
                check("cmd_no_vld", ch_rxd_vld, '0);
                check("cmd_no_tack", ch_txd_ack, '0);
                @(negedge clk);
                phy_rxd_vld = 1'b0;
                phy_txd_ack = 1'b0;
            end
            phy_txc_ack = 1'b1;
            #1;
            check($sformatf("beat%0d", b), phy_txc, eb[b]);
            @(negedge clk);
            phy_txc_ack = 1'b0;
        end
        check("ack_one_cycle", ch_ack, '0);

        for (int w = 0; w < n; w++) begin
            wc = spur ? int'($urandom_range(0, 2)) : 0;
            repeat (wc) begin
                if (r) phy_txd_ack = 1'b1; else phy_rxd_vld = 1'b1;
                #1;
                check("data_idle_tack", ch_txd_ack, '0);
                check("data_idle_vld", ch_rxd_vld, '0);
                check("data_no_fin", phy_fin, 1'b0);
                @(negedge clk);
                phy_txd_ack = 1'b0;
                phy_rxd_vld = 1'b0;
            end
            ch_txd = {$urandom, $urandom};
            ch_txm = 8'($urandom);
            wd = ch_txd[g*DW +: DW];
            wm = ch_txm[g*2 +: 2];
            rd = 16'($urandom);
            phy_rxd = rd;
            if (r) phy_rxd_vld = 1'b1; else phy_txd_ack = 1'b1;
            #1;
            if (r) begin
                check("rd_data", ch_rxd, rd);
                check("rd_vld", ch_rxd_vld, 4'b0001 << g);
                check("rd_no_tack", ch_txd_ack, '0);
            end else begin
                check("wr_data", phy_txd, wd);
                check("wr_mask", phy_txm, wm);
                check("wr_tack", ch_txd_ack, 4'b0001 << g);
            end
            check("req_in_data", phy_req, 1'b1);
            @(negedge clk);
            phy_txd_ack = 1'b0;
            phy_rxd_vld = 1'b0;
        end

        #1;
        check("fin_pulse", phy_fin, 1'b1);
        check("fin_req_low", phy_req, 1'b0);
        @(negedge clk);
        check("fin_one_cycle", phy_fin, 1'b0);
    endtask

    typedef struct {
        int          ch;
        logic        rwn;
        logic        burst;
        logic [31:0] addr;
        logic [15:0] b0, b1, b2;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int rr_exp [5];
        logic [NCH-1:0] got;
        int n2;

        tbl[0] = '{ch: 1, rwn: 1'b1, burst: 1'b0, addr: 32'h0000_1235, b0: 16'hA000, b1: 16'h0246, b2: 16'h0005};
        tbl[1] = '{ch: 0, rwn: 1'b0, burst: 1'b1, addr: 32'h0000_0000, b0: 16'h2000, b1: 16'h0000, b2: 16'h0000};
        tbl[2] = '{ch: 3, rwn: 1'b0, burst: 1'b0, addr: 32'hFFFF_FFFF, b0: 16'h3FFF, b1: 16'hFFFF, b2: 16'h0007};
        tbl[3] = '{ch: 2, rwn: 1'b1, burst: 1'b1, addr: 32'h8000_0008, b0: 16'hB000, b1: 16'h0001, b2: 16'h0000};
        rr_exp = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        ch_req = 4'hF; ch_rwn = '0; ch_burst = '0; ch_addr = '0;
        ch_txm = '0; ch_txd = '0; req2 = '0;
        phy_txc_ack = 1'b0; phy_txd_ack = 1'b0; phy_rxd_vld = 1'b0;
        phy_rxd = 16'h5A5A;
        #1 rst = 1'b0;

        // Reset state, with requests and read data present.
        repeat (3) @(negedge clk);
        check("rst_ack", ch_ack, '0);
        check("rst_txd_ack", ch_txd_ack, '0);
        check("rst_rxd", ch_rxd, '0);
        check("rst_rxd_vld", ch_rxd_vld, '0);
        check("rst_phy_req", phy_req, 1'b0);
        check("rst_phy_fin", phy_fin, 1'b0);
        check("rst_phy_rwn", phy_rwn, 1'b0);
        check("rst_phy_txc", phy_txc, '0);
        check("rst_phy_txm", phy_txm, '0);
        check("rst_phy_txd", phy_txd, '0);
        check("rst_prio_ack", ack2, '0);

        rst = 1'b1;
        ptr_m = 0;
        phy_rxd = '0;

        // Round robin with all channels requesting continuously.
        ch_rwn = 4'hF;
        ch_addr = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            run_txn(4'hF, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, got);
            check($sformatf("rr_order%0d", i), got, 4'b0001 << rr_exp[i]);
        end
        ch_req = '0;

        // Directed vectors with hand-computed command beats.
        for (int i = 0; i < 4; i++) begin
            ch_rwn[tbl[i].ch]                = tbl[i].rwn;
            ch_burst[tbl[i].ch]              = tbl[i].burst;
            ch_addr[tbl[i].ch*AW +: AW]      = tbl[i].addr;
            run_txn(4'b0001 << tbl[i].ch, 1'b0, 1'b1, tbl[i].b0, tbl[i].b1, tbl[i].b2, 1'b1, got);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 30; i++) begin
            ch_rwn   = 4'($urandom);
            ch_burst = 4'($urandom);
            ch_addr  = {$urandom, $urandom, $urandom, $urandom};
            run_txn(4'($urandom_range(1, 15)), 1'($urandom), 1'b0, 16'h0, 16'h0, 16'h0, 1'($urandom), got);
        end
        ch_req = '0;

        // Reset in the middle of a burst read.
        ch_rwn[2] = 1'b1;
        ch_burst[2] = 1'b1;
        ch_req = 4'b0100;
        @(negedge clk);
        check("abort_grant", ch_ack, 4'b0100);
        ch_req = '0;
        phy_txc_ack = 1'b1;
        repeat (3) @(negedge clk);
        phy_txc_ack = 1'b0;
        phy_rxd_vld = 1'b1;
        phy_rxd = 16'hC3C3;
        repeat (3) @(negedge clk);
        check("abort_mid_vld", ch_rxd_vld, 4'b0100);
        #2 rst = 1'b0;
        #1;
        check("abort_req", phy_req, 1'b0);
        check("abort_fin", phy_fin, 1'b0);
        check("abort_vld", ch_rxd_vld, '0);
        check("abort_rxd", ch_rxd, '0);
        check("abort_rwn", phy_rwn, 1'b0);
        check("abort_txc", phy_txc, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_fin", phy_fin, 1'b0);
        end
        phy_rxd_vld = 1'b0;
        rst = 1'b1;
        ptr_m = 0;
        ch_rwn[1] = 1'b0;
        ch_burst[1] = 1'b0;
        run_txn(4'b0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, got);
        check("post_abort_grant", got, 4'b0010);

        // Fixed priority: channel 2 beats channel 3 while it keeps asking.
        req2 = 4'b1100;
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack2 != '0) begin
                check("prio_ch2", ack2, 4'b0100);
                n2++;
            end
        end
        check("prio_grants_seen", n2 >= 3, 1'b1);
        req2 = 4'b1000;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (got == '0 && ack2 != '0) got = ack2;
        end
        check("prio_ch3_after_drop", got, 4'b1000);
        req2 = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arb_mc.md
Name: ram_arb_mc

Overview:
- Parametrised multi-channel front end for the HyperRAM PHY.
- Succeeds the fixed two-source hub (one host port plus one mgmt port) with NCH identical host channels.
- Arbitration is round-robin or fixed priority; burst length is configurable.
- Builds the 48-bit command/address word and sends it to the PHY in three 16-bit beats. It then routes write data to, and read data from, the granted channel.

Parameters:
- NCH, 4, number of host channels (2..8).
- AW, 32, host halfword address width.
- DW, 16, data width per PHY beat.
- BURST_LEN, 8, words per burst access (power of two, 2..64).
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- ch_req  in  NCH  per-channel access request; held until ch_ack.
- ch_rwn  in  NCH  1 = read, 0 = write.
- ch_burst  in  NCH  1 = BURST_LEN words, 0 = single word.
- ch_addr  in  NCH*AW  packed halfword addresses; channel i at [i*AW +: AW].
- ch_ack  out  NCH  one-cycle grant pulse.
- ch_txm  in  NCH*2  packed write byte masks.
- ch_txd  in  NCH*DW  packed write data.
- ch_txd_ack  out  NCH  write word consumed.
- ch_rxd  out  DW  read data, broadcast to all channels.
- ch_rxd_vld  out  NCH  read word valid, granted channel only.
- phy_req  out  1  transaction active.
- phy_fin  out  1  transaction end pulse.
- phy_rwn  out  1  direction of the current transaction.
- phy_txc  out  16  command beat.
- phy_txc_ack  in  1  command beat consumed.
- phy_txm  out  2  write mask.
- phy_txd  out  DW  write data.
- phy_txd_ack  in  1  write word consumed.
- phy_rxd  in  DW  read data from the PHY.
- phy_rxd_vld  in  1  read word valid.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0; the FSM is in IDLE; the RR pointer is 0; the grant register is cleared.
  - Reset mid-transaction drops phy_req with no phy_fin. The PHY treats this as an abort.
- FSM states: IDLE, CMD, DATA, FIN.
- IDLE:
  - If any ch_req is high at an edge, the arbiter selects channel g.
  - At that edge the block registers g, rwn, burst and addr, sets ch_ack[g]=1 for one cycle, sets phy_req=1 and enters CMD.
  - Latency from req to ack is 1 cycle.
- Arbitration:
  - RR: search starts at the pointer. After a grant the pointer becomes (g+1) mod NCH.
  - Fixed priority: the lowest-index requester wins.
  - Requests withdrawn before being sampled are ignored.
- CMD:
  - The 48-bit CA word is assembled as follows.
    - [47] = rwn.
    - [46] = 0 (memory space).
    - [45] = 1 (linear burst).
    - [44:16] = addr[31:3].
    - [15:3] = 0.
    - [2:0] = addr[2:0].
  - phy_txc carries beat 0 = CA[47:32], beat 1 = CA[31:16], beat 2 = CA[15:0].
  - The beat index advances on phy_txc_ack. Ack on beat 2 moves the FSM to DATA.
  - The word counter loads BURST_LEN (burst=1) or 1 (burst=0).
- DATA, write:
  - phy_txd and phy_txm mirror ch_txd and ch_txm of g combinationally.
  - ch_txd_ack[g] = phy_txd_ack; all other txd_ack bits are 0.
  - The counter decrements on each ack.
- DATA, read:
  - ch_rxd = phy_rxd at all times.
  - ch_rxd_vld[g] = phy_rxd_vld while in DATA; 0 elsewhere.
  - The counter decrements on each vld.
- Leaving DATA: the counter reaching 0 (last ack or vld) moves the FSM to FIN.
- FIN:
  - phy_fin=1 and phy_req=0 for one cycle, then IDLE.
  - Minimum gap between consecutive phy_req pulses is 2 cycles (FIN, IDLE).
- phy_rwn is the registered rwn, valid from CMD through FIN.
- Address wrap: addr[31:3] overflow is not checked. The linear burst continues in the device, and the block does not split it.
- Simultaneous events:
  - A new req arriving during CMD, DATA or FIN waits; it is not acked until IDLE.
  - phy_rxd_vld outside DATA is ignored.
  - phy_txd_ack in a read, or phy_rxd_vld in a write, is ignored.
- Width rules:
  - Counter width is clog2(BURST_LEN)+1.
  - Grant index width is clog2(NCH).

Decomposition:
- Shared package ram_pkg holds:
  - FSM state encoding;
  - CA bit-position constants (CA_RW, CA_AS, CA_BT);
  - a clog2 function.
- Sub-module ram_rr_arb is the NCH-wide arbiter: request vector plus pointer in; one-hot grant and index out; PRIO_MODE selects RR or fixed.

Test Plan:
- Single read, ch1, addr 0x0000_1235: ch_ack[1] one cycle after req. Beats are 0xA000, 0x0246, 0x0005. One vld gives ch_rxd_vld[1]=1, then phy_fin pulses.
- Burst write, ch0, BURST_LEN=8, txm=2'b00: exactly 8 ch_txd_ack[0] pulses. phy_txd follows ch_txd; phy_fin comes after the 8th ack.
- RR, all four channels requesting continuously: grants go 0,1,2,3,0. No channel is granted twice before the others.
- PRIO_MODE=1, ch2 and ch3 requesting continuously: only ch2 is granted while its req stays high.
- rst asserted during DATA of a burst read: all outputs are 0 asynchronously and phy_fin never pulses. After release, a new req is granted normally.
- Spurious inputs: phy_rxd_vld pulsed during CMD and phy_txd_ack pulsed during a read cause no ch_rxd_vld, no ch_txd_ack and no counter change.
